wb_queue: RTL and testbench
===========================

# wb_queue

Write-back queue sitting directly upstream of the register file's single write port. It buffers up to DEPTH pending register writes from the execute/memory stages and drains one per cycle into the register file's write_en/waddr/data_in. Optionally, it forwards still-queued values to the read stage so reads never observe a stale register.

## Interface
- W, 8: data path width; matches the register file.
- D, 3: register pointer width; matches the register file.
- DEPTH, 4: queue entries; power of two, at least 2.
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  producer has a write to enqueue.
- in_ready  out  1  queue accepts this cycle.
- in_addr  in  D  destination register.
- in_data  in  W  value to write.
- hold  in  1  1 stalls draining; the head entry stays.
- wr_en  out  1  to register file write_en.
- wr_addr  out  D  to register file waddr.
- wr_data  out  W  to register file data_in.
- look_addrA, look_addrB  in  D  read-stage addresses, same as the register file raddrA/raddrB.
- hitA, hitB  out  1  a queued entry targets the look address.
- fwdA, fwdB  out  W  youngest queued value for that address.
- count  out  $clog2(DEPTH)+1  occupied entries.
- empty, full  out  1  count==0 / count==DEPTH.

## Operation
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Accept: in_valid && in_ready. The entry {in_addr, in_data} is written at tail, and tail advances.
- in_ready = !full || (wr_en). A full queue still accepts when the head is popping in the same cycle.
- Drain: wr_en = !empty && !hold. wr_addr/wr_data show the head entry; both are 0 when empty. When wr_en=1, the entry pops on the clock edge as the register file commits it.
- Simultaneous accept and pop: count is unchanged and both pointers advance. With a single entry present, that entry pops while the new one becomes the head.
- in_valid with in_ready=0: nothing is written and no state changes. The producer holds its data.
- Address 0 is an ordinary destination, because the register file writes it.
- Lookup (when compiled in): every occupied entry is compared against look_addrA/B.
  - hit is set if any entry matches.
  - fwd is taken from the youngest match, nearest tail.
  - The head entry being written this cycle still counts as a hit.
  - In-flight in_* data is not compared.
- No data-dependent arithmetic. Pointers and count are the only counters.

## Timing
- Accept at edge N: the entry appears on wr_* from edge N onward, once it is at the head. It is visible to lookup after edge N. The register file holds the value after edge N+1 at the earliest.
- wr_en, in_ready, hit, and fwd are combinational from registered state plus hold/look_addr. No input-to-output path runs from in_* to wr_*.
- While reset=0:
  - count=0, empty=1, full=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - hitA/B=0, fwdA/B=0.
  - in_ready=0.
  - Entry storage is cleared to 0.
- First edge after reset releases: in_ready=1.
- Reset asserted mid-operation discards all pending writes, and wr_en drops the same cycle.

## Configuration
- WBQ_BYPASS_EN defined: lookup comparators and the hitA/B and fwdA/B logic are built as described.
- Not defined: hitA/B are tied 0, fwdA/B are tied 0, and look_addr inputs are unused. The read stage must then stall until empty=1 before reading a register with a pending write.

## Test plan
- Reset release, then enqueue (addr 3, 0x5A) with hold=0 → wr_en=1, wr_addr=3, wr_data=0x5A for one cycle, then empty=1 and count=0.
- hold=1, enqueue 4 entries (1,0x11)(2,0x22)(3,0x33)(4,0x44) → full=1, in_ready=0, and a fifth in_valid is ignored. Release hold → four consecutive wr_en cycles in order 1,2,3,4.
- Full queue, hold=0, in_valid with (5,0x55) → in_ready=1 and the entry is accepted. count stays 4, and 0x55 drains last.
- Bypass: hold=1, enqueue (2,0x10) then (2,0x20), look_addrA=2 → hitA=1, fwdA=0x20. look_addrB=6 → hitB=0, fwdB=0.
- Pointer wrap: stream 10 entries at one per cycle with hold=0 → wr_* reproduces all 10 in order with no gaps after the first.
- Assert reset low with 3 entries queued mid-drain → wr_en=0 and count=0 immediately. After release, empty=1 and no stale write occurs.

Source files
------------

// File: rtl/wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Define WBQ_BYPASS_EN to build the lookup/forwarding path (hitA/B, fwdA/B).
module wb_queue #(
    parameter int W     = 8,
    parameter int D     = 3,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [D-1:0]           in_addr,
    input  logic [W-1:0]           in_data,
    input  logic                   hold,
    output logic                   wr_en,
    output logic [D-1:0]           wr_addr,
    output logic [W-1:0]           wr_data,
    input  logic [D-1:0]           look_addrA,
    input  logic [D-1:0]           look_addrB,
    output logic                   hitA,
    output logic                   hitB,
    output logic [W-1:0]           fwdA,
    output logic [W-1:0]           fwdB,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q;
    logic   [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic   [CW-1:0]    count_q, count_d;
    logic               push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign wr_en    = !empty && !hold;
    // A full queue still accepts when the head leaves on the same edge.
    assign in_ready = reset && (!full || wr_en);
    assign push     = in_valid && in_ready;
    assign pop      = wr_en;
    assign wr_addr  = empty ? '0 : mem_q[head_q].addr;
    assign wr_data  = empty ? '0 : mem_q[head_q].data;

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) mem_q[tail_q] <= {in_addr, in_data};
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        idx  = '0;
        hitA = 1'b0;
        hitB = 1'b0;
        fwdA = '0;
        fwdB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (mem_q[idx].addr == look_addrA) begin
                    hitA = 1'b1;
                    fwdA = mem_q[idx].data;
                end
                if (mem_q[idx].addr == look_addrB) begin
                    hitB = 1'b1;
                    fwdB = mem_q[idx].data;
                end
            end
        end
    end
`else
    logic unused_look;

    assign unused_look = ^{look_addrA, look_addrB};
    assign hitA = 1'b0;
    assign hitB = 1'b0;
    assign fwdA = '0;
    assign fwdB = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a queue-based reference model predicts status and
// lookup results, accepted writes go to a scoreboard that a monitor drains against wr_*.
module tb_wb_queue;
    localparam int W = 8, D = 3, DEPTH = 4;

    logic         CLK = 1'b0;
    logic         reset, in_valid, in_ready, hold, wr_en, hitA, hitB, empty, full;
    logic [D-1:0] in_addr, wr_addr, look_addrA, look_addrB;
    logic [W-1:0] in_data, wr_data, fwdA, fwdB;
    logic [2:0]   count;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } ent_t;

    ent_t mdl[$];    // reference contents, oldest first
    ent_t exp_q[$];  // expected register-file writes, in order

    always #5 CLK = ~CLK;

    wb_queue #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .hold(hold), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .look_addrA(look_addrA),
        .look_addrB(look_addrB), .hitA(hitA), .hitB(hitB), .fwdA(fwdA),
        .fwdB(fwdB), .count(count), .empty(empty), .full(full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void look(input logic [D-1:0] la, output logic h, output logic [W-1:0] f);
        h = 1'b0;
        f = '0;
`ifdef WBQ_BYPASS_EN
        foreach (mdl[i]) begin
            if (mdl[i].a == la) begin
                h = 1'b1;
                f = mdl[i].d;
            end
        end
`endif
    endfunction

    // Monitor: every register-file write must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge CLK);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    chk("wr_addr", 32'(wr_addr), 32'(exp_q[0].a));
                    chk("wr_data", 32'(wr_data), 32'(exp_q[0].d));
                    exp_q.delete(0);
                end
            end
        end
    end

    // One cycle: drive at posedge+1, check at negedge, advance the model for the next edge.
    task automatic step(input logic r, input logic v, input logic [D-1:0] a,
                        input logic [W-1:0] d, input logic h,
                        input logic [D-1:0] la, input logic [D-1:0] lb);
        int       n;
        logic     ewen, erdy, eh;
        logic [W-1:0] ef;
        ent_t     e;
        reset      = r;
        in_valid   = v;
        in_addr    = a;
        in_data    = d;
        hold       = h;
        look_addrA = la;
        look_addrB = lb;
        if (!r) begin
            mdl.delete();
            exp_q.delete();
        end
        @(negedge CLK);
        n    = mdl.size();
        ewen = r && (n > 0) && !h;
        erdy = r && ((n < DEPTH) || ewen);
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("wr_en", 32'(wr_en), 32'(ewen));
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        if (n == 0) begin
            chk("wr_addr_idle", 32'(wr_addr), 32'h0);
            chk("wr_data_idle", 32'(wr_data), 32'h0);
        end else if (h) begin
            chk("head_addr", 32'(wr_addr), 32'(mdl[0].a));
            chk("head_data", 32'(wr_data), 32'(mdl[0].d));
        end
        look(la, eh, ef);
        chk("hitA", 32'(hitA), 32'(eh));
        chk("fwdA", 32'(fwdA), 32'(ef));
        look(lb, eh, ef);
        chk("hitB", 32'(hitB), 32'(eh));
        chk("fwdB", 32'(fwdB), 32'(ef));
        e.a = a;
        e.d = d;
        if (v && erdy) exp_q.push_back(e);
        if (ewen) mdl.delete(0);
        if (v && erdy) mdl.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; hold = 1'b0;
        look_addrA = '0; look_addrB = '0;
        @(posedge CLK);
        #1;
        step(0, 1, 3'd5, 8'hAA, 0, 3'd0, 3'd0);
        step(0, 0, 3'd0, 8'h00, 1, 3'd0, 3'd0);

        // Single write passes straight through.
        step(1, 1, 3'd3, 8'h5A, 0, 3'd3, 3'd0);
        step(1, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0);
        step(1, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0);

        // Fill under hold, fifth write refused, then drain in order.
        step(1, 1, 3'd1, 8'h11, 1, 3'd1, 3'd4);
        step(1, 1, 3'd2, 8'h22, 1, 3'd1, 3'd4);
        step(1, 1, 3'd3, 8'h33, 1, 3'd1, 3'd4);
        step(1, 1, 3'd4, 8'h44, 1, 3'd1, 3'd4);
        step(1, 1, 3'd7, 8'h77, 1, 3'd4, 3'd7);
        for (int i = 0; i < 5; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd2, 3'd0);

        // Full queue accepts while popping.
        for (int i = 0; i < 4; i++) step(1, 1, 3'(i), 8'(8'h60 + i), 1, 3'd0, 3'd3);
        step(1, 1, 3'd5, 8'h55, 0, 3'd5, 3'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd5, 3'd0);

        // Youngest match forwards.
        step(1, 1, 3'd2, 8'h10, 1, 3'd2, 3'd6);
        step(1, 1, 3'd2, 8'h20, 1, 3'd2, 3'd6);
        step(1, 0, 3'd0, 8'h00, 1, 3'd2, 3'd6);
        step(1, 0, 3'd0, 8'h00, 0, 3'd2, 3'd6);
        for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd2, 3'd0);

        // Pointer wrap: back-to-back stream.
        for (int i = 0; i < 10; i++) step(1, 1, 3'(i), 8'(8'hA0 + i), 0, 3'(i), 3'(i + 1));
        for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1, $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0);

        // Reset mid-drain discards pending writes.
        for (int i = 0; i < 4; i++) step(1, 1, 3'(i + 4), 8'(8'hC0 + i), 1, 3'd5, 3'd6);
        step(1, 0, 3'd0, 8'h00, 0, 3'd5, 3'd6);
        step(0, 0, 3'd0, 8'h00, 0, 3'd5, 3'd6);
        for (int i = 0; i < 4; i++) step(1, 0, 3'd0, 8'h00, 0, 3'd5, 3'd6);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
